// File: rtl/tick_scheduler_pkg.sv
// Shared types for the tick scheduler: FSM state encoding and a helper
// for sizing the prescaler.
package tick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A prescaler must be at least one bit wide, even when it never counts.
  function automatic int presc_width(input int clock_delay);
    return (clock_delay > 1) ? $clog2(clock_delay) : 1;
  endfunction

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping around, returned both one-hot and as an index.
module rr_arbiter
  import tick_scheduler_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  // Walk the requesters starting at ptr; the extra sum bit absorbs the wrap.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shares one prescaled tick down-counter between NUM_REQ requesters,
// granting it round-robin and pulsing done to the owner when it expires.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 4,
  parameter int CLOCK_DELAY = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_delay,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [COUNT_WIDTH-1:0]         count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = presc_width(CLOCK_DELAY);
  localparam logic [PW-1:0]          PRESC_MAX = PW'(CLOCK_DELAY - 1);
  localparam logic [IW-1:0]          LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]       done_q, done_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [PW-1:0]            presc_q, presc_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            owner_q, owner_d;
  logic [IW-1:0]            owner_next;
  logic [NUM_REQ-1:0]       arb_onehot;
  logic [IW-1:0]            arb_idx;
  logic [COUNT_WIDTH-1:0]   delay_arr [NUM_REQ];
  logic [COUNT_WIDTH-1:0]   arb_delay;
  logic                     any_req;
  logic                     tick;
  logic                     cancel;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      delay_arr[i] = req_delay[i*COUNT_WIDTH +: COUNT_WIDTH];
    end
  end

  assign arb_delay  = delay_arr[arb_idx];
  assign any_req    = |req;
  assign tick       = (presc_q == PRESC_MAX);
  assign cancel     = !req[owner_q];
  assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // A dropped owner request wins over a tick landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = (arb_delay == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (tick && count_q == COUNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
    presc_d = presc_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = arb_onehot;
          owner_d = arb_idx;
          count_d = arb_delay;
          presc_d = '0;
          if (arb_delay == '0) begin
            done_d = arb_onehot;
          end
        end
      end
      ST_RUN: begin
        if (cancel) begin
          grant_d = '0;
          count_d = '0;
          presc_d = '0;
          ptr_d   = owner_next;
        end else if (tick) begin
          presc_d = '0;
          count_d = count_q - 1'b1;
          if (count_q == COUNT_ONE) begin
            done_d = grant_q;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        presc_d = '0;
        ptr_d   = owner_next;
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
